mult_share_arbiter: RTL and testbench

- Shares one sequential 4x4 signed multiplier core between two requesters, A and B.
- Each requester presents operands with a Req/Ack handshake. The block grants access round-robin, pulses the core start, waits for core halt (with a watchdog), and returns the 8-bit signed product on a one-cycle valid strobe to the granted requester.
- Sits between the switch/register front end and the multiplier core, replacing direct register-to-core wiring.

---
 rtl/mult_pkg.sv | 7 +
 rtl/rr_arbiter2.sv | 15 +
 rtl/mult_share_arbiter.sv | 84 ++++++++
 tb/tb_mult_share_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared states, requester ids and sizing for the multiplier-sharing arbiter
package mult_pkg;
    localparam int MULT_WIDTH = 4;
    localparam int MULT_TIMEOUT = 15;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
    typedef enum logic {REQ_A, REQ_B} req_id_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; a tie goes to the requester not served last
module rr_arbiter2
    import mult_pkg::*;
(
    input  logic    req_a,
    input  logic    req_b,
    input  req_id_t last,
    output req_id_t winner,
    output logic    any_req
);
    always_comb begin
        any_req = req_a | req_b;
        winner  = (req_a && (!req_b || last == REQ_B)) ? REQ_A : REQ_B;
    end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one sequential multiplier core between requesters A and B
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int WIDTH   = MULT_WIDTH,
    parameter int TIMEOUT = MULT_TIMEOUT
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               ReqA,
    input  logic [WIDTH-1:0]   MultiplierA,
    input  logic [WIDTH-1:0]   MultiplicandA,
    output logic               AckA,
    output logic [2*WIDTH-1:0] ProductA,
    output logic               ValidA,
    input  logic               ReqB,
    input  logic [WIDTH-1:0]   MultiplierB,
    input  logic [WIDTH-1:0]   MultiplicandB,
    output logic               AckB,
    output logic [2*WIDTH-1:0] ProductB,
    output logic               ValidB,
    output logic               CoreStart,
    output logic [WIDTH-1:0]   CoreMultiplier,
    output logic [WIDTH-1:0]   CoreMultiplicand,
    input  logic [2*WIDTH-1:0] CoreProduct,
    input  logic               CoreHalt,
    output logic               Busy,
    output logic               Error
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t        state, state_nxt;
    req_id_t       winner, winner_q, last;
    logic          any_req, halt_ok, timed_out;
    logic [CW-1:0] cnt;
    rr_arbiter2 u_arb (
        .req_a   (ReqA),
        .req_b   (ReqB),
        .last    (last),
        .winner  (winner),
        .any_req (any_req)
    );
    always_ff @(posedge Clock) state <= Reset ? IDLE : state_nxt;
    always_comb begin
        halt_ok   = CoreHalt && cnt != '0;
        timed_out = cnt == CW'(TIMEOUT - 1);
        state_nxt = state == IDLE  ? (any_req ? ISSUE : IDLE)
                  : state == ISSUE ? WAIT
                  : state == WAIT  ? ((halt_ok || timed_out) ? RESPOND : WAIT)
                  : IDLE;
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            winner_q         <= REQ_A;
            last             <= REQ_B;
            cnt              <= '0;
            CoreMultiplier   <= '0;
            CoreMultiplicand <= '0;
            ProductA         <= '0;
            ProductB         <= '0;
            Error            <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                winner_q         <= winner;
                CoreMultiplier   <= winner == REQ_A ? MultiplierA : MultiplierB;
                CoreMultiplicand <= winner == REQ_A ? MultiplicandA : MultiplicandB;
            end
            cnt <= state == WAIT ? cnt + 1'b1 : '0;
            if (state == WAIT && (halt_ok || timed_out)) begin
                if (winner_q == REQ_A) ProductA <= halt_ok ? CoreProduct : '0;
                else ProductB <= halt_ok ? CoreProduct : '0;
                if (!halt_ok) Error <= 1'b1;
            end
            if (state == RESPOND) last <= winner_q;
        end
    end
    always_comb begin
        Busy      = state != IDLE;
        CoreStart = state == ISSUE;
        AckA      = CoreStart && winner_q == REQ_A;
        AckB      = CoreStart && winner_q == REQ_B;
        ValidA    = state == RESPOND && winner_q == REQ_A;
        ValidB    = state == RESPOND && winner_q == REQ_B;
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed table, corner sequences and random traffic against a transaction-level model
module tb_mult_share_arbiter;
    import mult_pkg::*;
    localparam int LAT = 5;
    logic Clock = 1'b0, Reset = 1'b1;
    logic ReqA = 1'b0, ReqB = 1'b0;
    logic [3:0] MultiplierA = '0, MultiplicandA = '0, MultiplierB = '0, MultiplicandB = '0;
    logic AckA, AckB, ValidA, ValidB, CoreStart, Busy, Error;
    logic [7:0] ProductA, ProductB;
    logic [3:0] CoreMultiplier, CoreMultiplicand;
    logic [7:0] CoreProduct = 8'h5A;
    logic CoreHalt = 1'b1;
    int checks = 0, errors = 0, cyc = 0;
    bit rand_mode = 1'b0, hang_next = 1'b0, cur_hang = 1'b0;

    typedef struct {
        bit rst, ra, rb, hang;
        logic [3:0] ma, da, mb, db;
        bit fb;
        logic [7:0] pa, pb;
        bit err;
    } vec_t;
    vec_t vt[6];

    always #5 Clock = ~Clock;

    mult_share_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .ReqA(ReqA), .MultiplierA(MultiplierA), .MultiplicandA(MultiplicandA),
        .AckA(AckA), .ProductA(ProductA), .ValidA(ValidA),
        .ReqB(ReqB), .MultiplierB(MultiplierB), .MultiplicandB(MultiplicandB),
        .AckB(AckB), .ProductB(ProductB), .ValidB(ValidB),
        .CoreStart(CoreStart), .CoreMultiplier(CoreMultiplier), .CoreMultiplicand(CoreMultiplicand),
        .CoreProduct(CoreProduct), .CoreHalt(CoreHalt), .Busy(Busy), .Error(Error)
    );

    function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
        int x;
        x = int'($signed(a)) * int'($signed(b));
        return x[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Core model: halt rises LAT cycles after start and drops one cycle late, so a stale halt is always visible in the first WAIT cycle
    int lat = 0;
    bit clr = 1'b0;
    logic [7:0] cprod = '0;
    always @(posedge Clock) begin
        if (CoreStart) begin
            lat   <= cur_hang ? 0 : LAT;
            clr   <= 1'b1;
            cprod <= prod(CoreMultiplier, CoreMultiplicand);
        end else begin
            if (clr) begin
                CoreHalt <= 1'b0;
                clr      <= 1'b0;
            end
            if (lat == 1) begin
                CoreHalt    <= 1'b1;
                CoreProduct <= cprod;
            end
            if (lat > 0) lat <= lat - 1;
        end
    end

    // Transaction-level reference: who should be granted, when the result is due, and what every output must hold
    bit pidle, pra, prb, mlast, pend, pwho, phang, pvalid, merr, ea, eb, va, vb, ci;
    logic [3:0] pma, pda, pmb, pdb, mcm, mcd;
    logic [7:0] pexp, mpa, mpb;
    int pcyc;
    always @(negedge Clock) begin
        cyc++;
        if (Reset) begin
            pidle = 1; pra = 0; prb = 0; mlast = 1; pend = 0; pvalid = 0; merr = 0;
            mpa = 0; mpb = 0; mcm = 0; mcd = 0;
        end else begin
            ci = pvalid || (pidle && !(pra || prb));
            ea = pidle && pra && (!prb || mlast);
            eb = pidle && prb && (!pra || !mlast);
            chk("AckA", AckA, ea);
            chk("AckB", AckB, eb);
            chk("CoreStart", CoreStart, ea || eb);
            if (ea || eb) begin
                pend = 1; pwho = eb; pcyc = cyc;
                phang = rand_mode ? ($urandom_range(0, 7) == 0) : hang_next;
                cur_hang = phang;
                mcm = eb ? pmb : pma;
                mcd = eb ? pdb : pda;
                pexp = phang ? 8'h00 : prod(mcm, mcd);
            end
            va = pend && !pwho && cyc == pcyc + (phang ? MULT_TIMEOUT + 1 : LAT + 2);
            vb = pend && pwho && cyc == pcyc + (phang ? MULT_TIMEOUT + 1 : LAT + 2);
            chk("ValidA", ValidA, va);
            chk("ValidB", ValidB, vb);
            if (va || vb) begin
                if (vb) mpb = pexp; else mpa = pexp;
                merr = merr | phang;
                mlast = pwho;
                pend = 0;
            end
            chk("Busy", Busy, !ci);
            chk("ProductA", ProductA, mpa);
            chk("ProductB", ProductB, mpb);
            chk("CoreMultiplier", CoreMultiplier, mcm);
            chk("CoreMultiplicand", CoreMultiplicand, mcd);
            chk("Error", Error, merr);
            pvalid = va || vb;
            pidle = ci;
            pra = ReqA; prb = ReqB;
            pma = MultiplierA; pda = MultiplicandA; pmb = MultiplierB; pdb = MultiplicandB;
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && Busy; i++) step();
        chk("wait_idle", Busy, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int first, nv, need;
        logic [7:0] ga, gb;
        if (v.rst) do_reset();
        hang_next = v.hang;
        ReqA = v.ra; MultiplierA = v.ma; MultiplicandA = v.da;
        ReqB = v.rb; MultiplierB = v.mb; MultiplicandB = v.db;
        need = int'(v.ra) + int'(v.rb);
        first = -1; nv = 0; ga = '0; gb = '0;
        for (int i = 0; i < 100 && nv < need; i++) begin
            step();
            if (AckA) begin ReqA = 0; if (first < 0) first = 0; end
            if (AckB) begin ReqB = 0; if (first < 0) first = 1; end
            if (ValidA) begin ga = ProductA; nv++; end
            if (ValidB) begin gb = ProductB; nv++; end
        end
        chk($sformatf("vec%0d_done", idx), nv, need);
        chk($sformatf("vec%0d_first", idx), first, int'(v.fb));
        if (v.ra) chk($sformatf("vec%0d_pa", idx), ga, v.pa);
        if (v.rb) chk($sformatf("vec%0d_pb", idx), gb, v.pb);
        chk($sformatf("vec%0d_err", idx), Error, v.err);
        ReqA = 0; ReqB = 0;
        step();
        step();
    endtask

    task automatic drv(input bit b, input int n);
        bit got;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 5)) step();
            if (b) begin ReqB = 1; MultiplierB = 4'($urandom); MultiplicandB = 4'($urandom); end
            else begin ReqA = 1; MultiplierA = 4'($urandom); MultiplicandA = 4'($urandom); end
            got = 0;
            for (int k = 0; k < 200 && !got; k++) begin
                step();
                got = b ? AckB : AckA;
            end
            chk(b ? "drv_ackB" : "drv_ackA", got, 1);
            if (b) ReqB = 0; else ReqA = 0;
        end
    endtask

    initial begin
        int at[3];
        int na, nv, ta, tv;
        vt[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'hE, 4'd0, 4'd0, 1'b0, 8'hFA, 8'h00, 1'b0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h8, 4'h8, 4'd7, 4'hF, 1'b0, 8'h40, 8'hF9, 1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h8, 4'h8, 4'd7, 4'hF, 1'b0, 8'h40, 8'hF9, 1'b0};
        vt[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd3, 4'd0, 4'd0, 1'b0, 8'h00, 8'h00, 1'b1};
        vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd5, 4'd5, 1'b1, 8'h00, 8'h19, 1'b1};
        vt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 4'hF, 4'd7, 4'd7, 1'b0, 8'hFF, 8'h31, 1'b1};
        do_reset();
        chk("rst_busy", Busy, 0);
        chk("rst_ack", {AckA, AckB, CoreStart}, 0);
        chk("rst_valid", {ValidA, ValidB}, 0);
        chk("rst_products", {ProductA, ProductB}, 0);
        chk("rst_core_ops", {CoreMultiplier, CoreMultiplicand}, 0);
        chk("rst_error", Error, 0);
        for (int i = 0; i < 6; i++) run_vec(vt[i], i);

        hang_next = 0;
        ReqA = 1; MultiplierA = 4'd2; MultiplicandA = 4'd6;
        na = 0;
        for (int i = 0; i < 60 && na < 3; i++) begin
            step();
            if (AckA) begin
                at[na] = i;
                na++;
                MultiplierA = 4'($urandom);
                MultiplicandA = 4'($urandom);
                if (na == 3) ReqA = 0;
            end
        end
        ReqA = 0;
        chk("held_grants", na, 3);
        chk("held_gap1", at[1] - at[0], 4 + LAT);
        chk("held_gap2", at[2] - at[1], 4 + LAT);
        wait_idle();

        ReqA = 1; MultiplierA = 4'd3; MultiplicandA = 4'd3;
        for (int i = 0; i < 20 && !AckA; i++) step();
        chk("rw_ack", AckA, 1);
        ReqA = 0;
        step(); step(); step();
        chk("rw_busy_in_wait", Busy, 1);
        Reset = 1;
        step();
        Reset = 0;
        chk("rw_busy", Busy, 0);
        chk("rw_valid", ValidA, 0);
        chk("rw_producta", ProductA, 0);
        chk("rw_core_ops", {CoreMultiplier, CoreMultiplicand}, 0);
        chk("rw_error", Error, 0);
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (ValidA) nv++;
        end
        chk("rw_no_valid", nv, 0);
        ReqB = 1; MultiplierB = 4'd5; MultiplicandB = 4'hD;
        ta = -1; tv = -1;
        for (int i = 0; i < 40 && tv < 0; i++) begin
            step();
            if (AckB) begin ta = i; ReqB = 0; end
            if (ValidB) tv = i;
        end
        chk("stale_halt_latency", tv - ta, LAT + 2);
        chk("rw_productb", ProductB, 8'hF1);
        wait_idle();

        rand_mode = 1;
        fork
            drv(1'b0, 25);
            drv(1'b1, 25);
        join
        wait_idle();
        rand_mode = 0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
